// File: rtl/rexta_mem_arbiter_if.sv
// Bundle of the IF/LS requester ports and the Rexta memory port seen by rexta_mem_arbiter.
// slave: the arbiter's view. master: the environment's view (front-end, LSU, memory).
interface rexta_mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                  if_req;
    logic [ADDR_W-1:0]     if_addr;
    logic                  if_gnt;
    logic                  if_rvalid;
    logic [DATA_W-1:0]     if_rdata;
    logic                  if_err;

    logic                  ls_req;
    logic                  ls_we;
    logic [ADDR_W-1:0]     ls_addr;
    logic [DATA_W-1:0]     ls_wdata;
    logic [DATA_W/8-1:0]   ls_be;
    logic                  ls_gnt;
    logic                  ls_rvalid;
    logic [DATA_W-1:0]     ls_rdata;
    logic                  ls_err;

    logic                  mem_req;
    logic                  mem_we;
    logic [ADDR_W-1:0]     mem_addr;
    logic [DATA_W-1:0]     mem_wdata;
    logic [DATA_W/8-1:0]   mem_be;
    logic                  mem_ack;
    logic [DATA_W-1:0]     mem_rdata;

    modport slave (
        input  if_req, if_addr,
        output if_gnt, if_rvalid, if_rdata, if_err,
        input  ls_req, ls_we, ls_addr, ls_wdata, ls_be,
        output ls_gnt, ls_rvalid, ls_rdata, ls_err,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        input  mem_ack, mem_rdata
    );

    modport master (
        output if_req, if_addr,
        input  if_gnt, if_rvalid, if_rdata, if_err,
        output ls_req, ls_we, ls_addr, ls_wdata, ls_be,
        input  ls_gnt, ls_rvalid, ls_rdata, ls_err,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/rexta_mem_arbiter.sv
// Shares the Rexta memory port between instruction fetch and load/store, one transaction at a time,
// with a watchdog abort. Define REXTA_ARB_RR_EN for round-robin ties; default is fixed LS-over-IF.
module rexta_mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              reset_n,
    rexta_mem_arbiter_if.slave bus
);
    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t                state_q;
    logic [CNT_W-1:0]      cnt_q;
    logic                  owner_ls_q;
    logic                  if_rvalid_q, ls_rvalid_q;
    logic                  if_err_q, ls_err_q;
    logic [DATA_W-1:0]     if_rdata_q, ls_rdata_q;

    logic                  we_q;
    logic [ADDR_W-1:0]     addr_q;
    logic [DATA_W-1:0]     wdata_q;
    logic [DATA_W/8-1:0]   be_q;

    logic                  busy;
    logic                  grant_d;
    logic                  pick_ls_d;

    assign busy    = (state_q == BUSY);
    // Gated by reset_n so a requester never sees a grant that the FSM then discards.
    assign grant_d = (state_q == IDLE) && reset_n && (bus.if_req || bus.ls_req);

`ifdef REXTA_ARB_RR_EN
    logic last_ls_q;

    assign pick_ls_d = bus.ls_req && (!bus.if_req || !last_ls_q);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            last_ls_q <= 1'b0;
        end else if (grant_d) begin
            last_ls_q <= pick_ls_d;
        end
    end
`else
    assign pick_ls_d = bus.ls_req;
`endif

    assign bus.ls_gnt = grant_d && pick_ls_d;
    assign bus.if_gnt = grant_d && !pick_ls_d;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            owner_ls_q  <= 1'b0;
            if_rvalid_q <= 1'b0;
            ls_rvalid_q <= 1'b0;
            if_err_q    <= 1'b0;
            ls_err_q    <= 1'b0;
            if_rdata_q  <= '0;
            ls_rdata_q  <= '0;
        end else begin
            if_rvalid_q <= 1'b0;
            ls_rvalid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (grant_d) begin
                        state_q    <= BUSY;
                        cnt_q      <= '0;
                        owner_ls_q <= pick_ls_d;
                    end
                end
                BUSY: begin
                    // An ack in the final watchdog cycle still counts as a normal completion.
                    if (bus.mem_ack || cnt_q == CNT_LAST) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                        if (owner_ls_q) begin
                            ls_rvalid_q <= 1'b1;
                            ls_err_q    <= !bus.mem_ack;
                            ls_rdata_q  <= (bus.mem_ack && !we_q) ? bus.mem_rdata : '0;
                        end else begin
                            if_rvalid_q <= 1'b1;
                            if_err_q    <= !bus.mem_ack;
                            if_rdata_q  <= bus.mem_ack ? bus.mem_rdata : '0;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Request payload is only visible while BUSY, so it needs no reset.
    always_ff @(posedge clk) begin
        if (grant_d) begin
            if (pick_ls_d) begin
                we_q    <= bus.ls_we;
                addr_q  <= bus.ls_addr;
                wdata_q <= bus.ls_wdata;
                be_q    <= bus.ls_be;
            end else begin
                we_q    <= 1'b0;
                addr_q  <= bus.if_addr;
                wdata_q <= '0;
                be_q    <= '1;
            end
        end
    end

    assign bus.mem_req   = busy;
    assign bus.mem_we    = busy && we_q;
    assign bus.mem_addr  = busy ? addr_q  : '0;
    assign bus.mem_wdata = busy ? wdata_q : '0;
    assign bus.mem_be    = busy ? be_q    : '0;

    assign bus.if_rvalid = if_rvalid_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.if_err    = if_err_q;
    assign bus.ls_rvalid = ls_rvalid_q;
    assign bus.ls_rdata  = ls_rdata_q;
    assign bus.ls_err    = ls_err_q;
endmodule
